// File: rtl/sysctrl_gen.sv
// MCU system-control slave: decodes the MCU command/data byte stream into LEDs, RGB colour,
// a flat config register file and edge-latched interrupt pending bits. SYSCTRL_READBACK_EN enables CMD 6 config readback.
module sysctrl_gen #(
    parameter logic [7:0]           CORE_ID     = 8'h02,
    parameter int unsigned          NUM_LEDS    = 2,
    parameter int unsigned          NUM_BUTTONS = 2,
    parameter int unsigned          NUM_CFG     = 32,
    parameter logic [7:0]           CFG_BASE    = 8'h41,
    parameter logic [8*NUM_CFG-1:0] CFG_DEFAULT = '0,
    parameter int unsigned          INT_CH      = 8,
    localparam int unsigned         CFG_AW      = (NUM_CFG > 1) ? $clog2(NUM_CFG) : 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   data_in_strobe,
    input  logic                   data_in_start,
    input  logic [7:0]             data_in,
    output logic [7:0]             data_out,
    output logic                   int_out_n,
    input  logic [INT_CH-1:0]      int_in,
    output logic [INT_CH-1:0]      int_ack,
    input  logic [NUM_BUTTONS-1:0] buttons,
    output logic [NUM_LEDS-1:0]    leds,
    output logic [23:0]            color,
    output logic [8*NUM_CFG-1:0]   cfg_vec,
    output logic                   cfg_wr_strobe,
    output logic [CFG_AW-1:0]      cfg_wr_index
);

    localparam logic [7:0] CMD_STATUS = 8'd0;
    localparam logic [7:0] CMD_LEDS   = 8'd1;
    localparam logic [7:0] CMD_COLOR  = 8'd2;
    localparam logic [7:0] CMD_BTNS   = 8'd3;
    localparam logic [7:0] CMD_CFGWR  = 8'd4;
    localparam logic [7:0] CMD_INT    = 8'd5;
    localparam logic [7:0] CMD_CFGRD  = 8'd6;
    localparam logic [3:0] STATE_MAX  = 4'd15;

    logic [3:0]             state_q, state_d;
    logic [7:0]             cmd_q, cmd_d;
    logic [7:0]             ptr_q, ptr_d;
    logic [7:0]             data_out_q, data_out_d;
    logic [NUM_LEDS-1:0]    leds_q, leds_d;
    logic [23:0]            color_q, color_d;
    logic [8*NUM_CFG-1:0]   cfg_q, cfg_d;
    logic                   cfg_wr_strobe_q, cfg_wr_strobe_d;
    logic [CFG_AW-1:0]      cfg_wr_index_q, cfg_wr_index_d;
    logic [INT_CH-1:0]      int_ack_q, int_ack_d;
    logic [INT_CH-1:0]      pending_q, pending_d;
    logic [INT_CH-1:0]      int_in_q, int_in_d;
    logic                   int_out_n_q, int_out_n_d;

    logic [7:0]             idx;
    logic [INT_CH-1:0]      rise;
    logic [INT_CH-1:0]      clr;
    logic [7:0]             rev;

    function automatic logic [7:0] rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[7-i];
        end
        return r;
    endfunction

    // Byte decode, config writes and interrupt pending update
    always_comb begin
        state_d         = state_q;
        cmd_d           = cmd_q;
        ptr_d           = ptr_q;
        data_out_d      = data_out_q;
        leds_d          = leds_q;
        color_d         = color_q;
        cfg_d           = cfg_q;
        cfg_wr_strobe_d = 1'b0;
        cfg_wr_index_d  = cfg_wr_index_q;
        int_ack_d       = '0;
        clr             = '0;
        idx             = ptr_q - CFG_BASE;
        rev             = rev8(data_in);
        rise            = int_in & ~int_in_q;
        rise[0]         = 1'b0;

        if (data_in_strobe) begin
            if (data_in_start) begin
                cmd_d   = data_in;
                state_d = 4'd1;
            end else if (state_q != 4'd0) begin
                case (cmd_q)
                    CMD_STATUS: begin
                        case (state_q)
                            4'd1:    data_out_d = 8'h5C;
                            4'd2:    data_out_d = 8'h42;
                            4'd3:    data_out_d = CORE_ID;
                            4'd4:    data_out_d = 8'(NUM_CFG);
                            default: ;
                        endcase
                    end
                    CMD_LEDS: begin
                        if (state_q == 4'd1) begin
                            leds_d = data_in[NUM_LEDS-1:0];
                        end
                    end
                    CMD_COLOR: begin
                        case (state_q)
                            4'd1:    color_d[15:8]  = rev;
                            4'd2:    color_d[7:0]   = rev;
                            4'd3:    color_d[23:16] = rev;
                            default: ;
                        endcase
                    end
                    CMD_BTNS: begin
                        data_out_d = 8'(buttons);
                    end
                    CMD_CFGWR: begin
                        if (state_q == 4'd1) begin
                            ptr_d = data_in;
                        end else begin
                            // Out-of-range slots still advance the pointer
                            if (32'(idx) < NUM_CFG) begin
                                for (int i = 0; i < NUM_CFG; i++) begin
                                    if (idx == 8'(i)) begin
                                        cfg_d[8*i +: 8] = data_in;
                                    end
                                end
                                cfg_wr_strobe_d = 1'b1;
                                cfg_wr_index_d  = CFG_AW'(idx);
                            end
                            ptr_d = ptr_q + 8'd1;
                        end
                    end
                    CMD_INT: begin
                        data_out_d = 8'(pending_q);
                        if (state_q == 4'd1) begin
                            clr       = data_in[INT_CH-1:0];
                            int_ack_d = data_in[INT_CH-1:0];
                        end
                    end
`ifdef SYSCTRL_READBACK_EN
                    CMD_CFGRD: begin
                        if (state_q == 4'd1) begin
                            ptr_d = data_in;
                        end else begin
                            data_out_d = 8'h00;
                            for (int i = 0; i < NUM_CFG; i++) begin
                                if (idx == 8'(i)) begin
                                    data_out_d = cfg_q[8*i +: 8];
                                end
                            end
                            ptr_d = ptr_q + 8'd1;
                        end
                    end
`else
                    CMD_CFGRD: ;
`endif
                    default: ;
                endcase
                if (state_q != STATE_MAX) begin
                    state_d = state_q + 4'd1;
                end
            end
        end

        // A new rising edge beats a simultaneous ack clear
        pending_d   = (pending_q & ~clr) | rise;
        int_in_d    = int_in;
        int_out_n_d = ~|pending_d;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q         <= '0;
            cmd_q           <= '0;
            ptr_q           <= '0;
            data_out_q      <= '0;
            leds_q          <= '0;
            color_q         <= '0;
            cfg_q           <= CFG_DEFAULT;
            cfg_wr_strobe_q <= 1'b0;
            cfg_wr_index_q  <= '0;
            int_ack_q       <= '0;
            pending_q       <= INT_CH'(1);
            int_in_q        <= '0;
            int_out_n_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            cmd_q           <= cmd_d;
            ptr_q           <= ptr_d;
            data_out_q      <= data_out_d;
            leds_q          <= leds_d;
            color_q         <= color_d;
            cfg_q           <= cfg_d;
            cfg_wr_strobe_q <= cfg_wr_strobe_d;
            cfg_wr_index_q  <= cfg_wr_index_d;
            int_ack_q       <= int_ack_d;
            pending_q       <= pending_d;
            int_in_q        <= int_in_d;
            int_out_n_q     <= int_out_n_d;
        end
    end

    assign data_out      = data_out_q;
    assign int_out_n     = int_out_n_q;
    assign int_ack       = int_ack_q;
    assign leds          = leds_q;
    assign color         = color_q;
    assign cfg_vec       = cfg_q;
    assign cfg_wr_strobe = cfg_wr_strobe_q;
    assign cfg_wr_index  = cfg_wr_index_q;

endmodule

// File: tb/tb_sysctrl_gen.sv
// Randomised bench for sysctrl_gen against a byte-level behavioural model of the MCU command protocol.
module tb_sysctrl_gen;

    localparam int unsigned NCFG = 32;
    localparam logic [7:0]  BASE = 8'h41;
    localparam logic [7:0]  CID  = 8'h02;
    localparam logic [8*NCFG-1:0] DEF = {8{32'hA5C3_0F96}};

    logic                clk = 1'b0;
    logic                reset_n;
    logic                strobe;
    logic                start;
    logic [7:0]          din;
    logic [7:0]          dout;
    logic                int_out_n;
    logic [7:0]          int_in;
    logic [7:0]          int_ack;
    logic [1:0]          buttons;
    logic [1:0]          leds;
    logic [23:0]         color;
    logic [8*NCFG-1:0]   cfg_vec;
    logic                cfg_wr_strobe;
    logic [4:0]          cfg_wr_index;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // model state
    int          m_cnt;
    logic [7:0]  m_cmd, m_ptr, m_dout, m_pend, m_prev, m_ack;
    logic [7:0]  m_cfg [NCFG];
    logic [1:0]  m_leds;
    logic [23:0] m_color;
    logic        m_wstb;
    logic [4:0]  m_widx;
    logic [7:0]  cur_int;

    sysctrl_gen #(
        .CORE_ID(CID), .NUM_LEDS(2), .NUM_BUTTONS(2), .NUM_CFG(NCFG),
        .CFG_BASE(BASE), .CFG_DEFAULT(DEF), .INT_CH(8)
    ) dut (
        .clk(clk), .reset_n(reset_n), .data_in_strobe(strobe), .data_in_start(start),
        .data_in(din), .data_out(dout), .int_out_n(int_out_n), .int_in(int_in),
        .int_ack(int_ack), .buttons(buttons), .leds(leds), .color(color),
        .cfg_vec(cfg_vec), .cfg_wr_strobe(cfg_wr_strobe), .cfg_wr_index(cfg_wr_index)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] bitrev(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
    endfunction

    // One clock of protocol behaviour, described per received byte
    task automatic model_step(input logic rst, input logic stb, input logic st,
                              input logic [7:0] d, input logic [7:0] ii, input logic [1:0] bt);
        logic [7:0] clr;
        logic [7:0] pend_old;
        logic [7:0] id;
        if (!rst) begin
            m_cnt = 0; m_cmd = 0; m_ptr = 0; m_dout = 0; m_leds = 0; m_color = 0;
            for (int i = 0; i < NCFG; i++) m_cfg[i] = DEF[8*i +: 8];
            m_wstb = 0; m_widx = 0; m_ack = 0; m_pend = 8'h01; m_prev = 0;
            return;
        end
        m_ack = 0; m_wstb = 0; clr = 0; pend_old = m_pend;
        if (stb && st) begin
            m_cmd = d; m_cnt = 1;
        end else if (stb && m_cnt != 0) begin
            case (m_cmd)
                8'd0: case (m_cnt)
                          1: m_dout = 8'h5C;
                          2: m_dout = 8'h42;
                          3: m_dout = CID;
                          4: m_dout = 8'(NCFG);
                          default: ;
                      endcase
                8'd1: if (m_cnt == 1) m_leds = d[1:0];
                8'd2: case (m_cnt)
                          1: m_color[15:8]  = bitrev(d);
                          2: m_color[7:0]   = bitrev(d);
                          3: m_color[23:16] = bitrev(d);
                          default: ;
                      endcase
                8'd3: m_dout = {6'd0, bt};
                8'd4: if (m_cnt == 1) m_ptr = d;
                      else begin
                          id = m_ptr - BASE;
                          if (id < 8'(NCFG)) begin
                              m_cfg[id[4:0]] = d; m_wstb = 1; m_widx = id[4:0];
                          end
                          m_ptr = m_ptr + 8'd1;
                      end
                8'd5: begin
                          m_dout = pend_old;
                          if (m_cnt == 1) begin clr = d; m_ack = d; end
                      end
`ifdef SYSCTRL_READBACK_EN
                8'd6: if (m_cnt == 1) m_ptr = d;
                      else begin
                          id = m_ptr - BASE;
                          m_dout = (id < 8'(NCFG)) ? m_cfg[id[4:0]] : 8'h00;
                          m_ptr = m_ptr + 8'd1;
                      end
`endif
                default: ;
            endcase
            if (m_cnt < 15) m_cnt++;
        end
        m_pend = (m_pend & ~clr) | (ii & ~m_prev & 8'hFE);
        m_prev = ii;
    endtask

    task automatic check_all();
        logic [8*NCFG-1:0] ecfg;
        for (int i = 0; i < NCFG; i++) ecfg[8*i +: 8] = m_cfg[i];
        chk("data_out", dout, m_dout);
        chk("leds", leds, m_leds);
        chk("color", color, m_color);
        chk("cfg_vec", cfg_vec, ecfg);
        chk("cfg_wr_strobe", cfg_wr_strobe, m_wstb);
        if (m_wstb) chk("cfg_wr_index", cfg_wr_index, m_widx);
        chk("int_ack", int_ack, m_ack);
        chk("int_out_n", int_out_n, m_pend == 8'h00);
    endtask

    // Drive inputs at a falling edge, let one rising edge pass, then compare
    task automatic cycle(input logic rst, input logic stb, input logic st, input logic [7:0] d);
        reset_n = rst; strobe = stb; start = st; din = d; int_in = cur_int;
        @(negedge clk);
        model_step(rst, stb, st, d, cur_int, buttons);
        strobe = 1'b0;
        check_all();
    endtask

    task automatic send(input logic st, input logic [7:0] d);
        cycle(1'b1, 1'b1, st, d);
    endtask

    task automatic idle();
        cycle(1'b1, 1'b0, 1'b0, 8'($urandom));
    endtask

    initial begin
        logic [7:0] seq [4];
        int unsigned r;
        seq[0] = 8'h5C; seq[1] = 8'h42; seq[2] = CID; seq[3] = 8'h20;
        reset_n = 1'b0; strobe = 1'b0; start = 1'b0; din = 8'h00;
        cur_int = 8'h00; int_in = 8'h00; buttons = 2'b10;
        @(negedge clk);

        cycle(1'b0, 1'b0, 1'b0, 8'h00);
        chk("reset_int_out_n", int_out_n, 1'b0);
        chk("reset_cfg", cfg_vec, DEF);
        idle();

        send(1'b1, 8'h00);
        for (int i = 0; i < 4; i++) begin
            send(1'b0, 8'hFF);
            chk("status_byte", dout, seq[i]);
        end
        idle();
        chk("status_hold", dout, 8'h20);

        send(1'b1, 8'h05);
        send(1'b0, 8'h01);
        chk("int_rd0", dout, 8'h01);
        chk("int_ack0", int_ack, 8'h01);
        send(1'b0, 8'h00);
        chk("int_rd1", dout, 8'h00);
        chk("int_ack_pulse", int_ack, 8'h00);
        chk("int_idle_n", int_out_n, 1'b1);

        cur_int = 8'h08; idle(); idle();
        chk("int3_pending", int_out_n, 1'b0);
        cur_int = 8'h00; idle();
        send(1'b1, 8'h05);
        cur_int = 8'h08;
        send(1'b0, 8'h08);
        chk("ack_race_rd", dout, 8'h08);
        chk("ack_race_ack", int_ack, 8'h08);
        chk("ack_race_keep", int_out_n, 1'b0);
        send(1'b0, 8'h00);
        chk("ack_race_rd2", dout, 8'h08);

        send(1'b1, 8'h04);
        send(1'b0, 8'h43);
        send(1'b0, 8'h11);
        chk("burst_idx2", cfg_wr_index, 5'd2);
        chk("slot2", cfg_vec[23:16], 8'h11);
        send(1'b0, 8'h22);
        chk("burst_idx3", cfg_wr_index, 5'd3);
        send(1'b0, 8'h33);
        chk("burst_idx4", cfg_wr_index, 5'd4);
        chk("slot4", cfg_vec[39:32], 8'h33);
        idle();

        send(1'b1, 8'h04);
        send(1'b0, 8'h60);
        send(1'b0, 8'hAA);
        chk("slot31", cfg_vec[255:248], 8'hAA);
        chk("slot31_stb", cfg_wr_strobe, 1'b1);
        send(1'b0, 8'hBB);
        chk("drop_stb", cfg_wr_strobe, 1'b0);

        send(1'b1, 8'h02);
        send(1'b0, 8'h80); send(1'b0, 8'h40); send(1'b0, 8'h01);
        chk("color_rev", color, 24'h80_01_02);

        send(1'b1, 8'h04);
        send(1'b0, 8'h41);
        send(1'b0, 8'h77);
        cycle(1'b0, 1'b1, 1'b0, 8'h55);
        chk("mid_reset_cfg", cfg_vec, DEF);
        send(1'b0, 8'h99);
        chk("ignored_byte", cfg_vec, DEF);
        chk("ignored_stb", cfg_wr_strobe, 1'b0);

        for (int n = 0; n < 3000; n++) begin
            buttons = 2'($urandom);
            if ($urandom_range(0, 9) == 0) cur_int[$urandom_range(0, 7)] ^= 1'b1;
            r = $urandom_range(0, 99);
            if (r < 1) begin
                cycle(1'b0, 1'($urandom), 1'($urandom), 8'($urandom));
            end else if (r < 15) begin
                send(1'b1, 8'($urandom_range(0, 7)));
            end else if (r < 60) begin
                if ((m_cmd == 8'd4 || m_cmd == 8'd6) && m_cnt == 1)
                    send(1'b0, BASE - 8'd2 + 8'($urandom_range(0, 36)));
                else
                    send(1'b0, 8'($urandom));
            end else begin
                idle();
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sysctrl_gen.md
Name: sysctrl_gen

Overview:
- Parametrised, core-independent successor of the MCU system-control slave.
- Decodes the MCU byte stream (start-flagged command byte, then data bytes). Drives LEDs, RGB colour and a generic indexed config register file.
- Latches interrupt requests as edge-triggered pending bits.
- Sits between the MCU SPI byte deserialiser and core glue; core glue slices named options out of cfg_vec.

Parameters:
- CORE_ID, 8'h02, core id returned by CMD 0 byte 3.
- NUM_LEDS, 2, MCU-controlled LED count (1..8).
- NUM_BUTTONS, 2, button input count (1..8).
- NUM_CFG, 32, config byte slots (1..64).
- CFG_BASE, 8'h41, id character mapped to slot 0 ("A").
- CFG_DEFAULT, {8*NUM_CFG{1'b0}}, reset value of cfg_vec; slot i is bits [8i+7:8i].
- INT_CH, 8, interrupt channels (1..8); channel 0 is the coldboot flag.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset: one clock; synchronous, active-low.
- data_in_strobe  in  1  one-cycle pulse, data_in valid.
- data_in_start  in  1  qualifies strobe: byte is a command byte.
- data_in  in  8  received byte.
- data_out  out  8  reply byte, read by MCU during the next transfer.
- int_out_n  out  1  low while any pending bit is set.
- int_in  in  INT_CH  interrupt request levels from core; bit 0 ignored.
- int_ack  out  INT_CH  one-cycle acknowledge pulses to core.
- buttons  in  NUM_BUTTONS  button levels.
- leds  out  NUM_LEDS  LED drive.
- color  out  24  RGB colour {R,G,B}.
- cfg_vec  out  8*NUM_CFG  config register file, flat.
- cfg_wr_strobe  out  1  one-cycle pulse after any config slot write.
- cfg_wr_index  out  CFG_AW=max(1,$clog2(NUM_CFG))  slot written by the last write.

Behaviour:
- Reset (reset_n=0 at clk edge):
  - state=0, data_out=0, leds=0, color=0, cfg_vec=CFG_DEFAULT.
  - cfg_wr_strobe=0, cfg_wr_index=0, int_ack=0.
  - pending=0 except pending[0]=1 (coldboot). int_in edge history register cleared to 0.
  - A reset mid-command aborts it; non-start bytes are ignored until the next start.
- Framing: strobe&start → command<=data_in, state<=1. Strobe&!start&state!=0 → decode, then state+1, saturating at 15. Strobe with state=0 is ignored.
- All outputs register on the strobe cycle. data_out holds its value on cycles without a strobe and on unknown commands.
- CMD 0 (status): state1→8'h5C; state2→8'h42; state3→CORE_ID; state4→NUM_CFG[7:0].
- CMD 1: state1 → leds<=data_in[NUM_LEDS-1:0].
- CMD 2: byte bit-reversed. state1→color[15:8], state2→color[7:0], state3→color[23:16].
- CMD 3: every data byte → data_out<=buttons zero-extended.
- CMD 4 (config burst write):
  - state1: ptr<=data_in.
  - Each later byte: idx=ptr-CFG_BASE (8-bit wrap). If idx<NUM_CFG, slot idx<=data_in, cfg_wr_strobe=1 next cycle, cfg_wr_index=idx.
  - ptr increments after every value byte (8-bit wrap). Out-of-range bytes are dropped, no strobe.
  - The burst continues past state saturation.
- CMD 5 (interrupts):
  - Every data byte: data_out<=pending zero-extended, pre-update value.
  - state1 only: pending&=~data_in; int_ack<=data_in[INT_CH-1:0] for one cycle.
- Pending logic:
  - i≥1: pending[i] set on rising edge of int_in[i], using the registered previous value.
  - A set in the same cycle as an ack-clear wins: bit stays 1.
  - pending[0] is cleared only by ack; it is never set after reset.
- int_out_n = ~|pending, registered.
- Unused CMD values: no effect.

Optional Feature:
- SYSCTRL_READBACK_EN defined: CMD 6 (config readback).
  - state1: ptr<=data_in.
  - Each later byte: data_out<=slot[ptr-CFG_BASE], or 8'h00 if out of range; then ptr++.
- Undefined: CMD 6 is an unused command with no effect; cfg_vec is write-only.

Test Plan:
- Reset, then CMD 0 + 4 data bytes → data_out sequence 5C,42,02,20; int_out_n=0 after reset (coldboot).
- CMD 5, data 8'h01, data 8'h00 → first reply 8'h01, int_ack=8'h01 for 1 cycle, second reply 8'h00, int_out_n=1.
- int_in[3] 0→1, held high → pending=8'h08, int_out_n=0. CMD 5 ack 8'h08 in the same cycle as a new int_in[3] rising edge → bit stays set.
- CMD 4, "C", 11,22,33 → slots 2,3,4 = 11,22,33; three cfg_wr_strobe pulses with indexes 2,3,4.
- CMD 4, id 8'h60 (idx 31), bytes AA,BB → slot31=AA, BB dropped, one strobe only.
- CMD 2 bytes 80,40,01 → color=24'h80_01_02; reset_n low mid-CMD 4 → cfg_vec=CFG_DEFAULT; following non-start byte ignored.
